// File: rtl/netlist_stim_seq_if.sv
// netlist_stim_seq_if: stimulus/capture bus between the sweep sequencer and its host.
interface netlist_stim_seq_if #(
    parameter int NUM_INPUTS = 6
);
    logic                  start;
    logic                  y_in;
    logic [NUM_INPUTS-1:0] stim_out;
    logic                  busy;
    logic                  done;
    logic [NUM_INPUTS:0]   ones_count;
    logic [15:0]           resp_sig;
    logic [NUM_INPUTS:0]   mismatch_cnt;
    logic [NUM_INPUTS-1:0] first_fail;
    logic                  first_fail_vld;
    modport master (
        output start, y_in,
        input  stim_out, busy, done, ones_count, resp_sig, mismatch_cnt, first_fail, first_fail_vld
    );
    modport slave (
        input  start, y_in,
        output stim_out, busy, done, ones_count, resp_sig, mismatch_cnt, first_fail, first_fail_vld
    );
endinterface

// File: rtl/netlist_stim_seq.sv
// netlist_stim_seq: exhaustive stimulus sweep of the gate netlist with ones-count and MISR capture.
// Define GOLDEN_CHECK_EN to add the golden-model compare (mismatch_cnt / first_fail).
module netlist_stim_seq #(
    parameter int          NUM_INPUTS    = 6,
    parameter int          SETTLE_CYCLES = 4,
    parameter logic [15:0] SIG_SEED      = 16'hACE1
) (
    input logic               clk,
    input logic               rst_n,
    netlist_stim_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    localparam logic [NUM_INPUTS-1:0] LAST   = '1;
    localparam logic [NUM_INPUTS-1:0] VONE   = 1;
    localparam logic [NUM_INPUTS:0]   CONE   = 1;
    localparam logic [7:0]            RELOAD = 8'(SETTLE_CYCLES - 1);
    state_t                state, state_nxt;
    logic [NUM_INPUTS-1:0] vec;
    logic [7:0]            timer;
    logic [NUM_INPUTS:0]   ones;
    logic [15:0]           sig;
    logic                  fb;
    logic                  accept;
    assign accept = state == IDLE && bus.start;
    assign fb     = sig[15] ^ sig[13] ^ sig[12] ^ sig[10];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    always_comb begin
        state_nxt = state == IDLE   ? (bus.start ? SETTLE : IDLE) :
                    state == SETTLE ? (timer == '0 ? SAMPLE : SETTLE) :
                    state == SAMPLE ? (vec == LAST ? DONE : SETTLE) : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec   <= '0;
            timer <= '0;
            ones  <= '0;
            sig   <= SIG_SEED;
        end else begin
            if (accept) begin
                vec   <= '0;
                timer <= RELOAD;
                ones  <= '0;
                sig   <= SIG_SEED;
            end
            if (state == SETTLE && timer != '0) timer <= timer - 8'd1;
            if (state == SAMPLE) begin
                ones <= ones + (bus.y_in ? CONE : '0);
                sig  <= {sig[14:0], fb} ^ {15'b0, bus.y_in};
                if (vec != LAST) begin
                    vec   <= vec + VONE;
                    timer <= RELOAD;
                end
            end
        end
    end
    // vec keeps the last vector through DONE; IDLE forces the bus back to zero
    assign bus.stim_out   = state == IDLE ? '0 : vec;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
    assign bus.ones_count = ones;
    assign bus.resp_sig   = sig;
`ifdef GOLDEN_CHECK_EN
    if (NUM_INPUTS != 6) begin : g_width_check
        $error("netlist_stim_seq: golden model requires NUM_INPUTS == 6");
    end
    logic                  t1, t2, t3, gold;
    logic [NUM_INPUTS:0]   mm;
    logic [NUM_INPUTS-1:0] ff;
    logic                  ffv;
    assign t1   = ~(vec[5] & vec[4]);
    assign t2   = vec[3] & ~vec[4] & vec[2];
    assign t3   = ~(vec[1] | vec[0]);
    assign gold = ~(t1 & t2 & t3);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mm  <= '0;
            ff  <= '0;
            ffv <= 1'b0;
        end else if (accept) begin
            mm  <= '0;
            ffv <= 1'b0;
        end else if (state == SAMPLE && bus.y_in != gold) begin
            mm <= mm + CONE;
            if (!ffv) begin
                ff  <= vec;
                ffv <= 1'b1;
            end
        end
    end
    assign bus.mismatch_cnt   = mm;
    assign bus.first_fail     = ff;
    assign bus.first_fail_vld = ffv;
`else
    assign bus.mismatch_cnt   = '0;
    assign bus.first_fail     = '0;
    assign bus.first_fail_vld = 1'b0;
`endif
endmodule

// File: tb/tb_netlist_stim_seq.sv
// tb_netlist_stim_seq: directed checks of the stimulus sweep with default and 1-cycle settle windows.
module tb_netlist_stim_seq;
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic sel;
    int   ymode;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;
    always #5 clk = ~clk;
    netlist_stim_seq_if #(.NUM_INPUTS(6)) b4 ();
    netlist_stim_seq_if #(.NUM_INPUTS(6)) b1 ();
    netlist_stim_seq #(.SETTLE_CYCLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
    netlist_stim_seq #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    // Correct netlist output is 0 only for {A..F} = 001100 and 101100
    function automatic logic gold(input logic [5:0] v);
        return !(v == 6'd12 || v == 6'd44);
    endfunction
    function automatic logic [15:0] misr_model(input int m);
        logic [15:0] s = 16'hACE1;
        logic        y;
        for (int v = 0; v < 64; v++) begin
            y = m == 0 ? gold(6'(v)) : (m == 1);
            s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]} ^ {15'b0, y};
        end
        return s;
    endfunction
    assign b4.start = start & ~sel;
    assign b1.start = start & sel;
    assign b4.y_in  = ymode == 0 ? gold(b4.stim_out) : (ymode == 1);
    assign b1.y_in  = ymode == 0 ? gold(b1.stim_out) : (ymode == 1);
    logic [5:0]  o_stim, o_ff;
    logic        o_busy, o_done, o_ffv;
    logic [6:0]  o_ones, o_mm;
    logic [15:0] o_sig;
    assign o_stim = sel ? b1.stim_out       : b4.stim_out;
    assign o_busy = sel ? b1.busy           : b4.busy;
    assign o_done = sel ? b1.done           : b4.done;
    assign o_ones = sel ? b1.ones_count     : b4.ones_count;
    assign o_sig  = sel ? b1.resp_sig       : b4.resp_sig;
    assign o_mm   = sel ? b1.mismatch_cnt   : b4.mismatch_cnt;
    assign o_ff   = sel ? b1.first_fail     : b4.first_fail;
    assign o_ffv  = sel ? b1.first_fail_vld : b4.first_fail_vld;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_stim"}, 32'(o_stim), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_done"}, 32'(o_done), 0);
        chk({tag, "_ones"}, 32'(o_ones), 0);
        chk({tag, "_sig"}, 32'(o_sig), 32'h0000ACE1);
        chk({tag, "_mm"}, 32'(o_mm), 0);
        chk({tag, "_ffv"}, 32'(o_ffv), 0);
    endtask
    // One sweep from IDLE, observed for a fixed cycle budget past the expected done
    task automatic run(input int restart_at, input int s, output int done_cyc, output int done_n,
                       output int busy_n, output logic stim_ok);
        int total;
        int ev;
        total    = 64 * (s + 1) + 1;
        done_cyc = 0;
        done_n   = 0;
        busy_n   = 0;
        stim_ok  = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= total + 3; c++) begin
            start = (c == restart_at);
            if (o_busy) busy_n++;
            if (o_done) begin
                done_n++;
                if (done_cyc == 0) done_cyc = c;
            end
            ev = c < total ? (c - 1) / (s + 1) : c == total ? 63 : 0;
            if (o_stim !== 6'(ev)) stim_ok = 1'b0;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask
    int   dc, dn, bn, idle, d2;
    logic sok, seen;
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        ymode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(0, 4, dc, dn, bn, sok);
        chk("model_done_cycle", 32'(dc), 321);
        chk("model_done_pulses", 32'(dn), 1);
        chk("model_busy_cycles", 32'(bn), 321);
        chk("model_stim_seq", 32'(sok), 1);
        chk("model_ones", 32'(o_ones), 62);
        chk("model_sig", 32'(o_sig), 32'(misr_model(0)));
        chk("model_mm", 32'(o_mm), 0);
        chk("model_ffv", 32'(o_ffv), 0);
        ymode = 1;
        run(0, 4, dc, dn, bn, sok);
        chk("tie1_ones", 32'(o_ones), 64);
        chk("tie1_sig", 32'(o_sig), 32'(misr_model(1)));
`ifdef GOLDEN_CHECK_EN
        chk("tie1_mm", 32'(o_mm), 2);
        chk("tie1_ff", 32'(o_ff), 12);
        chk("tie1_ffv", 32'(o_ffv), 1);
`else
        chk("tie1_mm", 32'(o_mm), 0);
        chk("tie1_ff", 32'(o_ff), 0);
        chk("tie1_ffv", 32'(o_ffv), 0);
`endif
        ymode = 2;
        run(0, 4, dc, dn, bn, sok);
        chk("tie0_ones", 32'(o_ones), 0);
        chk("tie0_sig", 32'(o_sig), 32'(misr_model(2)));
        chk("tie0_busy_cycles", 32'(bn), 321);
        chk("tie0_done_cycle", 32'(dc), 321);
        sel   = 1'b1;
        ymode = 0;
        run(0, 1, dc, dn, bn, sok);
        chk("s1_done_cycle", 32'(dc), 129);
        chk("s1_stim_seq", 32'(sok), 1);
        chk("s1_ones", 32'(o_ones), 62);
        chk("s1_busy_cycles", 32'(bn), 129);
        sel = 1'b0;
        run(100, 4, dc, dn, bn, sok);
        chk("restart_done_cycle", 32'(dc), 321);
        chk("restart_done_pulses", 32'(dn), 1);
        chk("restart_ones", 32'(o_ones), 62);
        chk("restart_sig", 32'(o_sig), 32'(misr_model(0)));
        ymode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (149) @(posedge clk);
        #1;
        chk("pre_rst_ones", 32'(o_ones), 29);
        chk("pre_rst_stim", 32'(o_stim), 29);
        rst_n = 1'b0;
        #1;
        chk_reset("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ymode = 0;
        run(0, 4, dc, dn, bn, sok);
        chk("post_rst_done_cycle", 32'(dc), 321);
        chk("post_rst_ones", 32'(o_ones), 62);
        ymode = 1;
        dn    = 0;
        idle  = 0;
        d2    = 0;
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 700; c++) begin
            if (o_done) begin
                dn++;
                if (dn == 2) d2 = c;
            end
            if (!o_busy) idle++;
            if (c == 322) chk("hold_ones_held", 32'(o_ones), 64);
            if (c == 323) chk("hold_ones_clr", 32'(o_ones), 0);
            if (c == 323) chk("hold_sig_seed", 32'(o_sig), 32'h0000ACE1);
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("hold_done_pulses", 32'(dn), 2);
        chk("hold_second_done", 32'(d2), 643);
        chk("hold_idle_cycles", 32'(idle), 2);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            seen = o_done;
            @(posedge clk); #1;
        end
        chk("hold_final_done", 32'(seen), 1);
        chk("hold_final_idle", 32'(o_busy), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/netlist_stim_seq.md
Name: netlist_stim_seq

Overview:
Upstream stimulus and capture stage for the six-input structural gate netlist (inputs A..F, output Y). On start, it drives all 2^NUM_INPUTS input vectors in ascending order and holds each one for a programmable settle window so gate delays resolve. At the end of each window it samples Y and folds it into a ones-count and a 16-bit response signature. A done pulse and stable result registers hand off to the bench or host.

Parameters:
NUM_INPUTS, 6, width of the stimulus vector; bit NUM_INPUTS-1 drives A, bit 0 drives F.
SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range is 1 to 255.
SIG_SEED, 16'hACE1, value loaded into the signature register on start.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  begin a sweep; sampled only in IDLE.
y_in  input  1  netlist output Y; treated as synchronous to clk after settling.
stim_out  output  NUM_INPUTS  current vector {A,B,C,D,E,F}.
busy  output  1  high from the cycle after start is accepted until DONE is left.
done  output  1  single-cycle pulse when the sweep completes.
ones_count  output  NUM_INPUTS+1  number of vectors for which the sampled Y was 1.
resp_sig  output  16  response signature (MISR).
mismatch_cnt  output  NUM_INPUTS+1  golden-compare failures (see Optional Feature).
first_fail  output  NUM_INPUTS  first failing vector.
first_fail_vld  output  1  first_fail holds a valid vector.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; stim_out=0; busy=0; done=0; ones_count=0; resp_sig=SIG_SEED; mismatch_cnt=0; first_fail=0; first_fail_vld=0; vector counter and timer cleared. Reset applied mid-sweep aborts immediately to these values; there is no partial result.
- States:
  - IDLE: start=1 clears ones_count, mismatch_cnt and first_fail_vld, loads resp_sig=SIG_SEED, sets vec=0 and timer=SETTLE_CYCLES-1, then goes to SETTLE.
  - SETTLE: stim_out=vec. When timer==0, go to SAMPLE; otherwise decrement the timer.
  - SAMPLE: stim_out=vec. At the closing edge, latch y_in, update ones_count and resp_sig, and run the golden compare if enabled. If vec == 2^NUM_INPUTS-1, go to DONE. Otherwise increment vec, reload the timer and go to SETTLE.
  - DONE: done=1 for exactly one cycle, busy=1, stim_out holds the last vector. Always returns to IDLE.
- busy=1 in SETTLE, SAMPLE and DONE.
- In IDLE, stim_out=0.
- Each vector is driven for exactly SETTLE_CYCLES+1 cycles, and Y is sampled at the last edge of that window.
- Latency: taking the start-accept edge as cycle 0, done is high in cycle 2^NUM_INPUTS*(SETTLE_CYCLES+1)+1. With the defaults, that is cycle 321.
- MISR update: resp_sig <= {resp_sig[14:0], resp_sig[15]^resp_sig[13]^resp_sig[12]^resp_sig[10]} ^ {15'b0, y}. Polynomial is x^16+x^14+x^13+x^11+1.
- ones_count saturates naturally, since its maximum of 2^NUM_INPUTS fits in its width.
- start while busy is ignored. start held high through DONE re-triggers only once the block is back in IDLE, i.e. one cycle after done.
- Results hold their values after DONE until the next accepted start or a reset.

Optional Feature:
Macro GOLDEN_CHECK_EN.
- Defined: instantiates a golden model of the netlist.
  - t1 = ~(A&B); t2 = C&~B&D; t3 = ~(E|F); Ygold = ~(t1&t2&t3).
  - In SAMPLE, if latched y differs from Ygold: mismatch_cnt increments. On the first mismatch of a sweep only, first_fail <= vec and first_fail_vld <= 1.
  - Valid only when NUM_INPUTS=6. Elaboration must fail for any other value.
- Undefined: mismatch_cnt, first_fail and first_fail_vld are tied to 0, with no compare logic.
- Both builds keep the same port list.

Test Plan:
- Drive y_in from a correct netlist model, SETTLE_CYCLES=4, pulse start -> done in cycle 321; ones_count=62; with the macro, mismatch_cnt=0 and first_fail_vld=0.
- Tie y_in=1 with the macro defined -> ones_count=64; mismatch_cnt=2; first_fail=12 (6'b001100); first_fail_vld=1.
- Tie y_in=0 -> ones_count=0; resp_sig equals a bench MISR model clocked 64 times from 16'hACE1 with zero input; busy=1 for exactly cycles 1..321.
- SETTLE_CYCLES=1 -> each stim_out value is stable for exactly 2 cycles; values step 0..63 in order; done in cycle 129.
- Pulse start again at cycle 100 mid-sweep -> ignored, results identical to the first test. Pull rst_n low at cycle 150 -> all outputs return to reset values asynchronously; a new start then completes normally.
- Hold start=1 continuously -> done pulses once per sweep, sweeps run back-to-back with one IDLE cycle between them, and results are cleared at each restart.
